// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One registered command per grant, held until memory completes, then a one-cycle release gap.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [1:0]        grant_id
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t            state, state_nxt;
    logic              last_d;
    logic              cmd_read, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              d_req, pick_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    assign d_req  = d_mem_read | d_mem_write;
    assign pick_d = d_req & (~i_mem_read | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (pick_d) begin
                    cmd_write <= d_mem_write;
                    cmd_read  <= d_mem_read & ~d_mem_write;
                    cmd_addr  <= d_mem_addr;
                    cmd_wdata <= d_mem_wdata;
                end else if (i_mem_read) begin
                    cmd_write <= 1'b0;
                    cmd_read  <= 1'b1;
                    cmd_addr  <= i_mem_addr;
                    cmd_wdata <= '0;
                end
            end
            if (state == GRANT_I && mem_ready) last_d <= 1'b0;
            if (state == GRANT_D && mem_ready) last_d <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        i_mem_rdata = '0;
        d_mem_rdata = '0;
        busy        = 1'b1;
        grant_id    = 2'd0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pick_d)          state_nxt = GRANT_D;
                else if (i_mem_read) state_nxt = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                mem_read  = cmd_read;
                mem_write = cmd_write;
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
                grant_id  = (state == GRANT_I) ? 2'd1 : 2'd2;
                if (mem_ready) begin
                    state_nxt = RELEASE;
                    if (state == GRANT_I) begin
                        i_mem_ready = 1'b1;
                        i_mem_rdata = mem_rdata;
                    end else begin
                        d_mem_ready = 1'b1;
                        d_mem_rdata = mem_rdata;
                    end
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the I-cache and D-cache miss/writeback interfaces of the pipelined RISC-V core. It registers one command per grant and holds it stable until memory completes. It returns ready/rdata only to the granted cache. Round-robin arbitration guarantees neither cache starves. It sits between the two L1 caches and the off-chip memory model.

Parameters:
ADDR_W, 28, memory block address width (word address >> 2)
DATA_W, 128, memory block data width (one 4-word cache line)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_mem_read  input  1  I-cache line-fill request, held until i_mem_ready
i_mem_addr  input  ADDR_W  I-cache block address
i_mem_rdata  output  DATA_W  line data to I-cache
i_mem_ready  output  1  one-cycle completion pulse to I-cache
d_mem_read  input  1  D-cache line-fill request
d_mem_write  input  1  D-cache writeback request
d_mem_addr  input  ADDR_W  D-cache block address
d_mem_wdata  input  DATA_W  D-cache writeback data
d_mem_rdata  output  DATA_W  line data to D-cache
d_mem_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  read command to memory
mem_write  output  1  write command to memory
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
mem_ready  input  1  memory completion, one cycle
busy  output  1  high in GRANT_I, GRANT_D or RELEASE
grant_id  output  2  0 = none, 1 = I-cache, 2 = D-cache

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; last_grant = I.
  - All outputs 0; command registers cleared.
  - Reset mid-transaction drops mem_read/mem_write immediately. No ready pulse is generated.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - Only I requests: go to GRANT_I.
  - Only D requests (read or write): go to GRANT_D.
  - Both request: grant the requester that is not last_grant. After reset, D wins the first tie.
  - On the grant edge, latch op, address and wdata from the winner into the command registers.
- GRANT_x:
  - mem_read, mem_write, mem_addr and mem_wdata are driven from the command registers.
  - The memory command appears one cycle after the request is first seen in IDLE.
  - Command stays stable until mem_ready, even if the requester deasserts (protocol violation tolerated).
  - When mem_ready=1:
    - Assert x_mem_ready combinationally in that same cycle.
    - Pass mem_rdata to x_mem_rdata.
    - Set last_grant = x and go to RELEASE.
- RELEASE:
  - Exactly one cycle; mem_read/mem_write = 0; then IDLE.
  - This gap lets caches drop the request before re-arbitration, so a stale request is never double-granted.
- Data outputs: i_mem_rdata and d_mem_rdata carry mem_rdata only in the owner's ready cycle, 0 otherwise. The ungranted ready is always 0.
- D read and write both asserted: write takes priority. The latched command has mem_write=1, mem_read=0. D must re-request the read afterwards.
- mem_ready in IDLE or RELEASE is ignored; no state change and no ready pulse.
- Minimum back-to-back spacing is 3 cycles per transaction (grant, ready, release). This holds when memory answers in the first grant cycle.
- Fairness: with both caches continuously requesting, grants strictly alternate I/D.
- grant_id = 1 in GRANT_I, 2 in GRANT_D, 0 otherwise.
- No combinational path from requester inputs to the mem_* outputs. All mem_* outputs are driven from state and the command registers.

Test Plan:
- I read only, addr=0x0000010, memory ready after 4 grant cycles, rdata=0xA5..A5 -> mem_read=1 and mem_addr=0x10 from cycle 1. i_mem_ready pulses once with i_mem_rdata=0xA5..A5. One RELEASE cycle, then IDLE. d_mem_ready stays 0.
- Simultaneous I read (0x20) and D write (0x30, wdata=0x1234) right after reset -> D granted first with mem_write=1, mem_addr=0x30. After the D ready and release, I is granted with mem_addr=0x20.
- Both caches request continuously for 6 transactions -> grant_id sequence 2,1,2,1,2,1. Each grant is separated by one RELEASE cycle.
- D asserts read and write together (addr 0x40) -> mem_write=1, mem_read=0. After the D re-requests read only, a separate read transaction is issued.
- I deasserts i_mem_read mid-grant; mem_ready arrives 3 cycles later -> mem_read stays 1 until mem_ready, i_mem_ready pulses once, state returns to IDLE. Spurious mem_ready in IDLE -> no ready pulse.
- rst_n pulled low during GRANT_D -> mem_write, busy and grant_id drop to 0 asynchronously. After release, a fresh tie grants D first.
